// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch handshake bundle: memory request/response and the
// decode-facing instruction channel. The master side is the fetch sequencer.
interface fetch_sequencer_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output instr_valid,
        output instr,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  instr_valid,
        input  instr,
        output instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one outstanding instruction-memory
// request at a time, holds the fetched word for decode and advances the PC
// (pc+4 or ALU target) when decode accepts. Flush redirects the PC and kills
// an in-flight response.
module fetch_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CNT_W     = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus,
    input  logic [31:0]        alu,
    input  logic               PCSel,
    input  logic               flush,
    input  logic [31:0]        flush_pc,
    output logic [31:0]        pc,
    output logic [31:0]        pc_4,
    output logic               misalign_err,
    output logic               fetch_timeout
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    // PC is word aligned, so only bits [31:2] are stored.
    logic [31:2]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               kill_q, kill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mis_q, mis_d;

    // Low bits of the flush target are dropped: fetch addresses are word aligned.
    logic               unused_flush_lsb;
    assign unused_flush_lsb = ^flush_pc[1:0];

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC[31:2];
            instr_q <= '0;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    // Next-state logic; flush overrides everything except BOOT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        kill_d  = kill_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;

        unique case (state_q)
            BOOT: begin
                state_d = REQ;
            end

            REQ: begin
                if (flush) begin
                    pc_d = flush_pc[31:2];
                end
                if (bus.imem_req_ready) begin
                    // An accepted request under flush fetches the stale
                    // address, so its response must be discarded.
                    state_d = WAIT;
                    cnt_d   = '0;
                    kill_d  = flush;
                end
            end

            WAIT: begin
                if (flush) begin
                    pc_d = flush_pc[31:2];
                end
                if (bus.imem_rsp_valid) begin
                    if (kill_q || flush) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d = bus.imem_rsp_data;
                        state_d = HOLD;
                    end
                end else begin
                    if (flush) begin
                        kill_d = 1'b1;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            HOLD: begin
                if (flush) begin
                    pc_d    = flush_pc[31:2];
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    if (PCSel) begin
                        pc_d = alu[31:2];
                        if (alu[1:0] != 2'b00) begin
                            mis_d = 1'b1;
                        end
                    end else begin
                        pc_d = pc_q + 30'd1;
                    end
                    state_d = REQ;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.imem_req_valid = (state_q == REQ);
    assign bus.imem_addr      = {pc_q, 2'b00};
    assign bus.instr_valid    = (state_q == HOLD);
    assign bus.instr          = instr_q;
    assign pc                 = {pc_q, 2'b00};
    assign pc_4               = {pc_q + 30'd1, 2'b00};
    assign misalign_err       = mis_q;
    // The counter only passes TIMEOUT-1 once per WAIT visit, giving a single pulse.
    assign fetch_timeout      = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the basic fetch and
// branch flow, then hand-written sequences for stalls, flushes, timeout,
// PC wrap and mid-operation reset. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_fetch_sequencer;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu;
    logic        PCSel;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        misalign_err;
    logic        fetch_timeout;

    int total;
    int bad;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_VEC (32'h0000_0000),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu           (alu),
        .PCSel         (PCSel),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .pc            (pc),
        .pc_4          (pc_4),
        .misalign_err  (misalign_err),
        .fetch_timeout (fetch_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rdata;
        logic        irdy;
        logic        psel;
        logic [31:0] alu;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic rqv, input logic [31:0] addr,
                       input logic iv, input logic [31:0] ins, input logic mis,
                       input logic to);
        logic [131:0] got;
        logic [131:0] exp;
        got = {bus.imem_req_valid, bus.imem_addr, pc, pc_4, bus.instr_valid,
               bus.instr, misalign_err, fetch_timeout};
        exp = {rqv, addr, addr, addr + 32'd4, iv, ins, mis, to};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got rqv=%b addr=%h pc=%h pc_4=%h iv=%b instr=%h mis=%b to=%b exp rqv=%b addr=%h pc_4=%h iv=%b instr=%h mis=%b to=%b",
                     nm, bus.imem_req_valid, bus.imem_addr, pc, pc_4, bus.instr_valid,
                     bus.instr, misalign_err, fetch_timeout,
                     rqv, addr, addr + 32'd4, iv, ins, mis, to);
        end
    endtask

    task automatic drv(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic irdy, input logic psel, input logic [31:0] a,
                       input logic fl, input logic [31:0] fpc);
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rdata;
        bus.instr_ready    = irdy;
        PCSel              = psel;
        alu                = a;
        flush              = fl;
        flush_pc           = fpc;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // rdy rv rdata irdy psel alu | rqv addr iv instr mis
        vq.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b0, 32'h0,         1'b0});
        vq.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h0,         1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b0, 32'h0,         1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 1'b1, 32'h0000_0013, 1'b0});
        vq.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 32'h0000_0013, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0,  1'b0, 32'h04, 1'b0, 32'h0000_0013, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b0, 32'h04, 1'b1, 32'h1111_1111, 1'b0});
        vq.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b0, 32'h1111_1111, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0,  1'b0, 32'h08, 1'b0, 32'h1111_1111, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h44, 1'b0, 32'h08, 1'b1, 32'h2222_2222, 1'b0});
        vq.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h2222_2222, 1'b0});
        vq.push_back('{1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0,  1'b0, 32'h44, 1'b0, 32'h2222_2222, 1'b0});
        vq.push_back('{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h46, 1'b0, 32'h44, 1'b1, 32'h3333_3333, 1'b0});
        vq.push_back('{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h3333_3333, 1'b1});
        vq.push_back('{1'b0, 1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'h0,  1'b0, 32'h44, 1'b0, 32'h3333_3333, 1'b1});
        vq.push_back('{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 1'b1, 32'h4444_4444, 1'b1});

        rst_n = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        alu      = '0;
        PCSel    = 1'b0;
        flush    = 1'b0;
        flush_pc = '0;
        repeat (3) @(negedge clk);
        chk("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Basic fetch stream, branch to 0x44, misaligned branch to 0x46.
        for (int i = 0; i < vq.size(); i++) begin
            chk($sformatf("vec%0d", i), vq[i].e_rqv, vq[i].e_addr, vq[i].e_iv,
                vq[i].e_instr, vq[i].e_mis, 1'b0);
            drv(vq[i].rdy, vq[i].rv, vq[i].rdata, vq[i].irdy, vq[i].psel,
                vq[i].alu, 1'b0, 32'h0);
        end

        // Decode stall in HOLD: nothing moves while PCSel toggles.
        for (int i = 0; i < 5; i++) begin
            chk("hold_stall", 1'b0, 32'h44, 1'b1, 32'h4444_4444, 1'b1, 1'b0);
            drv(1'b1, 1'b1, 32'h55, 1'b0, i[0], 32'h200, 1'b0, 32'h0);
        end
        chk("hold_stall_end", 1'b0, 32'h44, 1'b1, 32'h4444_4444, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
        chk("stall_accept", 1'b1, 32'h48, 1'b0, 32'h4444_4444, 1'b1, 1'b0);

        // Flush in WAIT kills the pending response.
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wait_pre_flush", 1'b0, 32'h48, 1'b0, 32'h4444_4444, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
        chk("wait_flushed", 1'b0, 32'h100, 1'b0, 32'h4444_4444, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("killed_rsp", 1'b1, 32'h100, 1'b0, 32'h4444_4444, 1'b1, 1'b0);
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("refetch_wait", 1'b0, 32'h100, 1'b0, 32'h4444_4444, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 32'h600D_0001, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("refetch_hold", 1'b0, 32'h100, 1'b1, 32'h600D_0001, 1'b1, 1'b0);

        // Flush in HOLD beats a simultaneous accept with PCSel.
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h200);
        chk("flush_hold", 1'b1, 32'h200, 1'b0, 32'h600D_0001, 1'b1, 1'b0);
        // Flush in REQ without ready: re-request at new address.
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h240);
        chk("flush_req", 1'b1, 32'h240, 1'b0, 32'h600D_0001, 1'b1, 1'b0);
        // Flush in REQ with ready: request counts as accepted and is killed.
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h280);
        chk("flush_req_rdy", 1'b0, 32'h280, 1'b0, 32'h600D_0001, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 32'hBAD0_0BAD, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("flush_req_drop", 1'b1, 32'h280, 1'b0, 32'h600D_0001, 1'b1, 1'b0);

        // Slow memory: one timeout pulse, then normal delivery.
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("timeout_c%0d", k), 1'b0, 32'h280, 1'b0, 32'h600D_0001, 1'b1,
                (k == TIMEOUT - 1));
            drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        end
        chk("timeout_late", 1'b0, 32'h280, 1'b0, 32'h600D_0001, 1'b1, 1'b0);
        drv(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("timeout_rsp", 1'b0, 32'h280, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("timeout_next", 1'b1, 32'h284, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);

        // PC wrap at the top of the address space.
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drv(1'b0, 1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap_hold", 1'b0, 32'hFFFF_FFFC, 1'b1, 32'h0000_0077, 1'b1, 1'b0);
        drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap_zero", 1'b1, 32'h0, 1'b0, 32'h0000_0077, 1'b1, 1'b0);

        // Reset mid-operation clears sticky error; BOOT ignores rsp and flush.
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("reset_mid", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("boot_after_reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
        chk("boot_ignores", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        drv(1'b0, 1'b1, 32'h0000_0099, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("req_ignores_rsp", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
